// File: rtl/ofmap_collector_if.sv
// ---------------------------------------------------------------------------
// ofmap_collector_if
// Bundles the result handshake, frame control, read port and status signals
// of the output-feature-map collector.
//   master : producer / reader side (drives frame_start, res_*, rd_en/rd_addr)
//   slave  : the collector (drives res_ready, rd_data/rd_valid, status)
// Signals:
//   frame_start  1  one-cycle pulse: clear buffer, begin a frame
//   res_valid    1  convolution result present on res_data
//   res_data    16  signed convolution result
//   res_ready    1  collector accepts res_data this cycle
//   rd_en        1  read request
//   rd_addr      4  read address
//   rd_data      8  registered read data
//   rd_valid     1  rd_data valid
//   frame_done   1  all results of the frame are stored (level)
//   wr_count     4  results accepted in the current frame
//   drop_err     1  sticky: result offered while not collecting
// ---------------------------------------------------------------------------
interface ofmap_collector_if;
    logic        frame_start;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        frame_done;
    logic [3:0]  wr_count;
    logic        drop_err;

    modport master (
        output frame_start, res_valid, res_data, rd_en, rd_addr,
        input  res_ready, rd_data, rd_valid, frame_done, wr_count, drop_err
    );

    modport slave (
        input  frame_start, res_valid, res_data, rd_en, rd_addr,
        output res_ready, rd_data, rd_valid, frame_done, wr_count, drop_err
    );
endinterface

// File: rtl/ofmap_collector.sv
// ---------------------------------------------------------------------------
// ofmap_collector
// Collects OUT_N convolution results of one frame into a small buffer,
// quantizing each 16-bit signed result to 8 bits, and serves registered
// random reads of the buffer.
// Parameters:
//   OUT_N  results per frame (1..15, wr_count/rd_addr are 4 bits)
//   SHIFT  arithmetic right shift applied before saturation
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (overrides everything)
//   bus    ofmap_collector_if.slave (handshake, read port, status)
// Build option:
//   OFMAP_RELU_EN  defined   -> clamp to unsigned 0..255 (ReLU)
//                  undefined -> saturate to signed -128..127
// ---------------------------------------------------------------------------
module ofmap_collector #(
    parameter int unsigned OUT_N = 9,
    parameter int unsigned SHIFT = 0
) (
    input logic              clk,
    input logic              reset,
    ofmap_collector_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [3:0] OUT_N_W  = 4'(OUT_N);
    localparam logic [3:0] LAST_IDX = 4'(OUT_N - 1);

    state_t      state_r;
    state_t      state_next_s;
    logic        res_ready_s;
    logic        accept_s;
    logic        drop_s;
    logic [3:0]  wr_count_r;
    logic        drop_err_r;
    logic [7:0]  rd_data_r;
    logic        rd_valid_r;
    logic [7:0]  mem_r [OUT_N];

    // Shift then clamp a raw result to the 8-bit stored format.
    function automatic logic [7:0] quantize(input logic signed [15:0] raw);
        logic signed [15:0] shifted;
        logic [7:0]         q;
        shifted = raw >>> SHIFT;
`ifdef OFMAP_RELU_EN
        if (shifted < 16'sd0) begin
            q = 8'd0;
        end else if (shifted > 16'sd255) begin
            q = 8'd255;
        end else begin
            q = shifted[7:0];
        end
`else
        if (shifted < -16'sd128) begin
            q = 8'h80;
        end else if (shifted > 16'sd127) begin
            q = 8'h7F;
        end else begin
            q = shifted[7:0];
        end
`endif
        return q;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and handshake qualifiers; frame_start always wins.
    always_comb begin
        state_next_s = state_r;
        res_ready_s  = 1'b0;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.frame_start) begin
                    state_next_s = ST_COLLECT;
                end else begin
                    drop_s = bus.res_valid;
                end
            end
            ST_COLLECT: begin
                if (bus.frame_start) begin
                    state_next_s = ST_COLLECT;
                end else begin
                    res_ready_s = 1'b1;
                    accept_s    = bus.res_valid;
                    if (bus.res_valid && (wr_count_r == LAST_IDX)) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Buffer, write counter, sticky drop flag and registered read port.
    // Accepts only happen in COLLECT where wr_count < OUT_N, so the counter
    // saturates at OUT_N without an explicit compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_r <= 4'd0;
            drop_err_r <= 1'b0;
            rd_data_r  <= 8'd0;
            rd_valid_r <= 1'b0;
            for (int i = 0; i < OUT_N; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else begin
            rd_valid_r <= bus.rd_en;
            // Reads see the pre-edge buffer, so a same-cycle write returns old data.
            if (bus.rd_en) begin
                rd_data_r <= (bus.rd_addr < OUT_N_W) ? mem_r[bus.rd_addr] : 8'd0;
            end else begin
                rd_data_r <= rd_data_r;
            end
            if (bus.frame_start) begin
                wr_count_r <= 4'd0;
                drop_err_r <= 1'b0;
                for (int i = 0; i < OUT_N; i++) begin
                    mem_r[i] <= 8'd0;
                end
            end else begin
                if (accept_s) begin
                    mem_r[wr_count_r] <= quantize($signed(bus.res_data));
                    wr_count_r        <= wr_count_r + 4'd1;
                end else begin
                    wr_count_r <= wr_count_r;
                end
                if (drop_s) begin
                    drop_err_r <= 1'b1;
                end else begin
                    drop_err_r <= drop_err_r;
                end
            end
        end
    end

    assign bus.res_ready  = res_ready_s;
    assign bus.rd_data    = rd_data_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.frame_done = (state_r == ST_DONE);
    assign bus.wr_count   = wr_count_r;
    assign bus.drop_err   = drop_err_r;

endmodule

// File: tb/tb_ofmap_collector.sv
// ---------------------------------------------------------------------------
// tb_ofmap_collector
// Directed, table-driven bench for ofmap_collector. dut0 uses SHIFT=0,
// dut2 uses SHIFT=2. Expected bytes are hand-computed for both the
// saturating and the ReLU build.
// ---------------------------------------------------------------------------
module tb_ofmap_collector;
`ifdef OFMAP_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [7:0]  exp_sat;
        logic [7:0]  exp_relu;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs [18];

    ofmap_collector_if bus0 ();
    ofmap_collector_if bus2 ();

    ofmap_collector #(.OUT_N(9), .SHIFT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    ofmap_collector #(.OUT_N(9), .SHIFT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_of(input int k);
        return RELU ? vecs[k].exp_relu : vecs[k].exp_sat;
    endfunction

    task automatic drive_frame(input int base);
        for (int i = 0; i < 9; i++) begin
            bus0.res_valid = 1'b1;
            bus0.res_data  = vecs[base + i].data;
            #1;
            check("ready_collect", 16'(bus0.res_ready), 16'd1);
            tick();
            if (i == 7) begin
                check("done_early", 16'(bus0.frame_done), 16'd0);
                check("count_8", 16'(bus0.wr_count), 16'd8);
            end
        end
        bus0.res_valid = 1'b0;
        #1;
        check("done_after_last", 16'(bus0.frame_done), 16'd1);
        check("count_sat", 16'(bus0.wr_count), 16'd9);
        check("ready_done", 16'(bus0.res_ready), 16'd0);
    endtask

    task automatic read_frame(input int base);
        for (int i = 0; i < 9; i++) begin
            bus0.rd_en   = 1'b1;
            bus0.rd_addr = 4'(i);
            tick();
            check("rd_valid", 16'(bus0.rd_valid), 16'd1);
            check($sformatf("rd_data[%0d]", i), 16'(bus0.rd_data), 16'(exp_of(base + i)));
        end
        bus0.rd_en = 1'b0;
        tick();
        check("rd_valid_idle", 16'(bus0.rd_valid), 16'd0);
    endtask

    task automatic read_zero(input string tag);
        for (int i = 0; i < 9; i++) begin
            bus0.rd_en   = 1'b1;
            bus0.rd_addr = 4'(i);
            tick();
            check($sformatf("%s[%0d]", tag, i), 16'(bus0.rd_data), 16'd0);
        end
        bus0.rd_en = 1'b0;
        tick();
    endtask

    task automatic accept_n(input int n, input logic [15:0] d);
        for (int i = 0; i < n; i++) begin
            bus0.res_valid = 1'b1;
            bus0.res_data  = d;
            tick();
        end
        bus0.res_valid = 1'b0;
    endtask

    initial begin
        // frame A: {-300, 0, 300} x3
        for (int i = 0; i < 9; i++) begin
            case (i % 3)
                0:       vecs[i] = '{-16'sd300, 8'h80, 8'h00};
                1:       vecs[i] = '{16'sd0,    8'h00, 8'h00};
                default: vecs[i] = '{16'sd300,  8'h7F, 8'hFF};
            endcase
        end
        // frame B: values around both saturation windows
        vecs[9]  = '{16'sd127,   8'h7F, 8'h7F};
        vecs[10] = '{16'sd128,   8'h7F, 8'h80};
        vecs[11] = '{-16'sd128,  8'h80, 8'h00};
        vecs[12] = '{-16'sd129,  8'h80, 8'h00};
        vecs[13] = '{16'sd255,   8'h7F, 8'hFF};
        vecs[14] = '{16'sd256,   8'h7F, 8'hFF};
        vecs[15] = '{-16'sd1,    8'hFF, 8'h00};
        vecs[16] = '{16'sd1,     8'h01, 8'h01};
        vecs[17] = '{16'sd5,     8'h05, 8'h05};

        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus0.frame_start = 1'b0; bus0.res_valid = 1'b0; bus0.res_data = 16'd0;
        bus0.rd_en = 1'b0;       bus0.rd_addr = 4'd0;
        bus2.frame_start = 1'b0; bus2.res_valid = 1'b0; bus2.res_data = 16'd0;
        bus2.rd_en = 1'b0;       bus2.rd_addr = 4'd0;
        tick();
        tick();
        check("rst_ready", 16'(bus0.res_ready), 16'd0);
        check("rst_rd_data", 16'(bus0.rd_data), 16'd0);
        check("rst_rd_valid", 16'(bus0.rd_valid), 16'd0);
        check("rst_done", 16'(bus0.frame_done), 16'd0);
        check("rst_count", 16'(bus0.wr_count), 16'd0);
        check("rst_drop", 16'(bus0.drop_err), 16'd0);
        reset = 1'b0;

        // frame A
        bus0.frame_start = 1'b1;
        #1;
        check("ready_fs_idle", 16'(bus0.res_ready), 16'd0);
        tick();
        bus0.frame_start = 1'b0;
        drive_frame(0);
        read_frame(0);

        // restart mid-frame with a concurrent result
        bus0.frame_start = 1'b1;
        tick();
        bus0.frame_start = 1'b0;
        accept_n(4, vecs[2].data);
        check("count_4", 16'(bus0.wr_count), 16'd4);
        bus0.frame_start = 1'b1;
        bus0.res_valid   = 1'b1;
        bus0.res_data    = 16'sd100;
        #1;
        check("ready_restart", 16'(bus0.res_ready), 16'd0);
        tick();
        bus0.frame_start = 1'b0;
        bus0.res_valid   = 1'b0;
        check("restart_count", 16'(bus0.wr_count), 16'd0);
        check("restart_drop", 16'(bus0.drop_err), 16'd0);
        read_zero("restart_mem");

        // frame B, then a dropped result in DONE
        drive_frame(9);
        read_frame(9);
        bus0.res_valid = 1'b1;
        bus0.res_data  = 16'sd5;
        tick();
        bus0.res_valid = 1'b0;
        check("drop_set", 16'(bus0.drop_err), 16'd1);
        check("drop_count", 16'(bus0.wr_count), 16'd9);
        check("drop_done", 16'(bus0.frame_done), 16'd1);
        bus0.rd_en = 1'b1; bus0.rd_addr = 4'd0;
        tick();
        check("drop_mem0", 16'(bus0.rd_data), 16'(exp_of(9)));
        bus0.rd_addr = 4'd8;
        tick();
        check("drop_mem8", 16'(bus0.rd_data), 16'(exp_of(17)));
        bus0.rd_en = 1'b0;
        bus0.frame_start = 1'b1;
        tick();
        bus0.frame_start = 1'b0;
        check("fs_drop_clr", 16'(bus0.drop_err), 16'd0);
        check("fs_done_clr", 16'(bus0.frame_done), 16'd0);
        check("fs_count_clr", 16'(bus0.wr_count), 16'd0);

        // read and write of address 0 in the same cycle returns the old byte
        bus0.rd_en = 1'b1; bus0.rd_addr = 4'd0;
        bus0.res_valid = 1'b1; bus0.res_data = vecs[2].data;
        tick();
        bus0.res_valid = 1'b0;
        check("rw_old", 16'(bus0.rd_data), 16'd0);
        check("rw_count", 16'(bus0.wr_count), 16'd1);
        tick();
        check("rw_new", 16'(bus0.rd_data), 16'(exp_of(2)));
        bus0.rd_addr = 4'd12;
        tick();
        check("oob12_valid", 16'(bus0.rd_valid), 16'd1);
        check("oob12_data", 16'(bus0.rd_data), 16'd0);
        bus0.rd_addr = 4'd0;
        tick();
        bus0.rd_addr = 4'd9;
        tick();
        check("oob9_data", 16'(bus0.rd_data), 16'd0);

        // reset after 5 accepts, with a read in flight
        bus0.rd_addr = 4'd0;
        accept_n(4, vecs[2].data);
        check("count_5", 16'(bus0.wr_count), 16'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_rd_data", 16'(bus0.rd_data), 16'd0);
        check("mid_rst_rd_valid", 16'(bus0.rd_valid), 16'd0);
        check("mid_rst_done", 16'(bus0.frame_done), 16'd0);
        check("mid_rst_count", 16'(bus0.wr_count), 16'd0);
        check("mid_rst_drop", 16'(bus0.drop_err), 16'd0);
        check("mid_rst_ready", 16'(bus0.res_ready), 16'd0);
        bus0.rd_en = 1'b0;
        read_zero("rst_mem");
        bus0.res_valid = 1'b1;
        tick();
        bus0.res_valid = 1'b0;
        check("idle_drop", 16'(bus0.drop_err), 16'd1);

        // SHIFT=2 instance
        bus2.frame_start = 1'b1;
        tick();
        bus2.frame_start = 1'b0;
        bus2.res_valid = 1'b1; bus2.res_data = 16'sd100;
        tick();
        bus2.res_data = 16'sd1023;
        tick();
        bus2.res_data = -16'sd9;
        tick();
        bus2.res_valid = 1'b0;
        check("sh_count", 16'(bus2.wr_count), 16'd3);
        bus2.rd_en = 1'b1; bus2.rd_addr = 4'd0;
        tick();
        check("sh_100", 16'(bus2.rd_data), 16'd25);
        bus2.rd_addr = 4'd1;
        tick();
        check("sh_1023", 16'(bus2.rd_data), RELU ? 16'd255 : 16'd127);
        bus2.rd_addr = 4'd2;
        tick();
        check("sh_neg9", 16'(bus2.rd_data), RELU ? 16'd0 : 16'h00FD);
        bus2.rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofmap_collector.md
OFMAP_COLLECTOR -- requirements
Module: ofmap_collector

Interface
REQ-001 The block SHALL have parameter OUT_N, default 9, meaning the number of output pixels per frame (3x3 map from a 5x5 image and a 3x3 kernel).
REQ-002 The block SHALL have parameter SHIFT, default 0, meaning the arithmetic right shift applied to each result before saturation.
REQ-003 clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse that clears the buffer and begins collecting a frame.
REQ-006 res_valid  input  1  a convolution result is present on res_data.
REQ-007 res_data  input  16  signed two's-complement convolution result.
REQ-008 res_ready  output  1  the block accepts res_data this cycle.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_addr  input  4  read address, 0..OUT_N-1.
REQ-011 rd_data  output  8  registered read data.
REQ-012 rd_valid  output  1  rd_data is valid this cycle.
REQ-013 frame_done  output  1  level; all OUT_N results are stored.
REQ-014 wr_count  output  4  number of results accepted in the current frame.
REQ-015 drop_err  output  1  sticky flag; a result was offered while not collecting.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT and DONE: IDLE->COLLECT on frame_start; COLLECT->DONE on the OUT_N-th accept; DONE->COLLECT on frame_start.
REQ-017 In COLLECT, frame_start SHALL restart the frame: wr_count->0, the buffer is cleared, and any res_valid in that cycle is ignored.
REQ-018 res_ready SHALL be 1 exactly when the state is COLLECT and frame_start is 0.
REQ-019 A transfer SHALL occur when res_valid and res_ready are both 1; the quantized value is written to address wr_count and wr_count increments in the same edge.
REQ-020 Quantization SHALL be: arithmetic shift of res_data right by SHIFT, then the clamp defined in REQ-029/REQ-030.
REQ-021 frame_done SHALL rise on the cycle after the OUT_N-th transfer and SHALL stay high until the next frame_start or reset.
REQ-022 wr_count SHALL saturate at OUT_N and SHALL never wrap.
REQ-023 res_valid with state IDLE or DONE SHALL set drop_err and SHALL not modify the buffer; frame_start SHALL clear drop_err.
REQ-024 Reads SHALL be allowed in any state, with rd_data and rd_valid driven one cycle after rd_en.
REQ-025 rd_addr >= OUT_N SHALL return rd_data 0 with rd_valid 1.
REQ-026 A read and a write to the same address in the same cycle SHALL return the old value.
REQ-027 frame_start SHALL zero all OUT_N buffer entries within one cycle.

Reset
REQ-028 Reset SHALL override all other inputs and SHALL force:
- state IDLE
- res_ready 0
- rd_data 0
- rd_valid 0
- frame_done 0
- wr_count 0
- drop_err 0
- buffer all zeros
Reset mid-frame SHALL discard the partial frame.

Configuration
REQ-029 With OFMAP_RELU_EN defined, quantization SHALL clamp negative values to 0 and positive values above 255 to 255, stored unsigned.
REQ-030 Without OFMAP_RELU_EN, quantization SHALL saturate to signed -128..127, stored two's complement.

Verification
REQ-031 Reset, frame_start, then 9 results (SHIFT=0, RELU_EN) {-300,0,300,-300,0,300,-300,0,300} with res_valid held -> frame_done=1 on the cycle after the 9th; reads of addr 0..8 return {0,0,255,0,0,255,0,0,255}.
REQ-032 Same stimulus without RELU_EN -> reads of addr 0..8 return {0x80,0x00,0x7F} repeated.
REQ-033 SHIFT=2, RELU_EN, result 100 -> stored value 25; result 1023 -> stored value 255.
REQ-034 Accept 4 results, then frame_start together with res_valid -> wr_count=0, all entries 0, the concurrent result is not stored, res_ready=0 in that cycle.
REQ-035 res_valid pulsed in DONE -> drop_err=1, buffer unchanged, wr_count stays 9; next frame_start -> drop_err=0, frame_done=0.
REQ-036 rd_en with rd_addr=12 -> rd_data=0 and rd_valid=1 next cycle; reset asserted after 5 accepts -> all outputs 0 and state IDLE on the following cycle.
